// File: rtl/heap_pkg.sv
// Shared state encoding and key ordering for the heap controller.
// Defining HEAP_MAX_EN turns the ordering into a max-heap; it is a min-heap by default.
package heap_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PU_CHK,
    S_PU_CMP,
    S_PU_WR,
    S_PO_RT,
    S_PO_LA,
    S_PO_LD,
    S_PO_CHL,
    S_PO_CHR,
    S_PO_SEL,
    S_PO_CMP,
    S_PO_WR,
    S_DONE
  } heap_state_e;

  // Keys up to 64 bits wide; unsigned zero-extension keeps the ordering intact.
  localparam int KEY_MAX_W = 64;

  function automatic logic better(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b);
`ifdef HEAP_MAX_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

endpackage

// File: rtl/heap_cmp.sv
// DW-wide heap ordering comparator: a_better is high when a belongs above b.
// Ordering follows HEAP_MAX_EN through heap_pkg::better().
module heap_cmp
  import heap_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          a_better
);

  assign a_better = better(KEY_MAX_W'(a), KEY_MAX_W'(b));

endmodule

// File: rtl/heap_ctrl.sv
// Binary-heap controller: push (sift-up) and pop (sift-down) over an external
// single-port synchronous RAM, 1-based indexing. Heap order selected by HEAP_MAX_EN.
//
// state    | meaning
// IDLE     | wait for push/pop request
// PU_CHK   | at root -> write, else read parent
// PU_CMP   | key better than parent -> move parent down
// PU_WR    | write key into hole
// PO_RT    | read root
// PO_LA    | latch root, read last element
// PO_LD    | last element becomes key, shrink heap
// PO_CHL   | no child -> write, else read left child
// PO_CHR   | latch left, read right if present
// PO_SEL   | pick better child
// PO_CMP   | child better than key -> move child up
// PO_WR    | write key into hole
// DONE     | one-cycle completion pulse
module heap_ctrl
  import heap_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 255,
  parameter int AW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] size,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  heap_state_e   state, state_nx;
  logic [DW-1:0] key, cand, dout_r;
  logic [AW-1:0] idx, cidx, size_r;
  logic          err_r;
  logic [AW:0]   lch, rch, size_w;
  logic [DW-1:0] cmp_a, cmp_b;
  logic          cmp_better;

  // Child indices carry one extra bit so they never wrap near DEPTH.
  assign lch    = {idx, 1'b0};
  assign rch    = {idx, 1'b1};
  assign size_w = {1'b0, size_r};

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign err   = done & err_r;
  assign dout  = dout_r;
  assign size  = size_r;
  assign empty = (size_r == '0);
  assign full  = (size_r == AW'(DEPTH));

  heap_cmp #(.DW(DW)) u_cmp (
    .a        (cmp_a),
    .b        (cmp_b),
    .a_better (cmp_better)
  );

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    cmp_a     = key;
    cmp_b     = mem_rdata;
    case (state)
      S_IDLE: begin
        if (pop_req)       state_nx = empty ? S_DONE : S_PO_RT;
        else if (push_req) state_nx = full ? S_DONE : S_PU_CHK;
      end
      S_PU_CHK: begin
        if (idx == AW'(1)) state_nx = S_PU_WR;
        else begin
          mem_addr = idx >> 1;
          state_nx = S_PU_CMP;
        end
      end
      S_PU_CMP: begin
        if (cmp_better) begin
          mem_wen   = 1'b1;
          mem_addr  = idx;
          mem_wdata = mem_rdata;
          state_nx  = S_PU_CHK;
        end else state_nx = S_PU_WR;
      end
      S_PU_WR, S_PO_WR: begin
        mem_wen   = 1'b1;
        mem_addr  = idx;
        mem_wdata = key;
        state_nx  = S_DONE;
      end
      S_PO_RT: begin
        mem_addr = AW'(1);
        state_nx = S_PO_LA;
      end
      S_PO_LA: begin
        mem_addr = size_r;
        state_nx = S_PO_LD;
      end
      S_PO_LD: state_nx = S_PO_CHL;
      S_PO_CHL: begin
        if (lch > size_w) state_nx = S_PO_WR;
        else begin
          mem_addr = lch[AW-1:0];
          state_nx = S_PO_CHR;
        end
      end
      S_PO_CHR: begin
        if (rch <= size_w) begin
          mem_addr = rch[AW-1:0];
          state_nx = S_PO_SEL;
        end else state_nx = S_PO_CMP;
      end
      S_PO_SEL: begin
        cmp_a    = mem_rdata;
        cmp_b    = cand;
        state_nx = S_PO_CMP;
      end
      S_PO_CMP: begin
        cmp_a = cand;
        cmp_b = key;
        if (cmp_better) begin
          mem_wen   = 1'b1;
          mem_addr  = idx;
          mem_wdata = cand;
          state_nx  = S_PO_CHL;
        end else state_nx = S_PO_WR;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      key    <= '0;
      cand   <= '0;
      dout_r <= '0;
      idx    <= '0;
      cidx   <= '0;
      size_r <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          err_r <= 1'b0;
          if (pop_req) begin
            if (empty) err_r <= 1'b1;
          end else if (push_req) begin
            if (full) err_r <= 1'b1;
            else begin
              key    <= din;
              idx    <= size_r + AW'(1);
              size_r <= size_r + AW'(1);
            end
          end
        end
        S_PU_CMP: if (cmp_better) idx <= idx >> 1;
        S_PO_LA:  dout_r <= mem_rdata;
        S_PO_LD: begin
          key    <= mem_rdata;
          size_r <= size_r - AW'(1);
          idx    <= AW'(1);
        end
        S_PO_CHR: begin
          cand <= mem_rdata;
          cidx <= lch[AW-1:0];
        end
        S_PO_SEL: if (cmp_better) begin
          cand <= mem_rdata;
          cidx <= rch[AW-1:0];
        end
        S_PO_CMP: if (cmp_better) idx <= cidx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_ctrl.sv
// Self-checking bench for heap_ctrl (DEPTH=7) against a sorted-queue priority model.
// Build with HEAP_MAX_EN defined to check the max-heap variant.
module tb_heap_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 7;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_req = 1'b0, pop_req = 1'b0;
  logic [DW-1:0] din = '0;
  logic          busy, done, err, empty, full, mem_wen;
  logic [DW-1:0] dout, mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] size, mem_addr;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [DW-1:0] ram [0:DEPTH];
  int model_q[$];

  heap_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req), .din(din),
    .busy(busy), .done(done), .err(err), .dout(dout), .size(size),
    .empty(empty), .full(full), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  function automatic bit ref_better(int a, int b);
`ifdef HEAP_MAX_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  function automatic void model_push(int k);
    model_q.push_back(k);
`ifdef HEAP_MAX_EN
    model_q.rsort();
`else
    model_q.sort();
`endif
  endfunction

  task automatic req(input bit pu, input bit po, input logic [DW-1:0] d,
                     output bit e, output logic [DW-1:0] q, output int lat);
    push_req = pu; pop_req = po; din = d;
    lat = 0; e = 1'b0; q = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); @(negedge clk);
      push_req = 1'b0; pop_req = 1'b0;
      if (done === 1'b1) begin
        lat = k; e = err; q = dout;
        break;
      end
    end
    if (lat == 0) begin
      errors++; checks++;
      $display("FAIL req_timeout: no done within 200 cycles (push=%0b pop=%0b)", pu, po);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_q.delete();
  endtask

  task automatic check_heap(string tag);
    checks++;
    if (int'(size) != model_q.size()) begin
      errors++;
      $display("FAIL %s_size: got %0d want %0d", tag, size, model_q.size());
    end
    for (int i = 2; i <= int'(size); i++)
      if (ref_better(int'(ram[i]), int'(ram[i/2]))) begin
        errors++;
        $display("FAIL %s_order: ram[%0d]=%0d above parent %0d", tag, i, ram[i], ram[i/2]);
      end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || size !== '0 || empty !== 1'b1 ||
        full !== 1'b0 || mem_addr !== '0 || mem_wen !== 1'b0 || mem_wdata !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b err=%b size=%0d empty=%b full=%b addr=%0d wen=%b wdata=%0d dout=%0d want 0,0,0,0,1,0,0,0,0,0",
               busy, done, err, size, empty, full, mem_addr, mem_wen, mem_wdata, dout);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_push_basic();
    int keys[4] = '{5, 3, 8, 1};
`ifdef HEAP_MAX_EN
    int exp_ram[4] = '{8, 3, 5, 1};
`else
    int exp_ram[4] = '{1, 3, 8, 5};
`endif
    bit e; logic [DW-1:0] q; int lat;
    foreach (keys[i]) begin
      req(1, 0, DW'(keys[i]), e, q, lat);
      model_push(keys[i]);
      checks++;
      if (e !== 1'b0 || size !== AW'(i + 1)) begin
        errors++;
        $display("FAIL push_basic: err=%b size=%0d want err=0 size=%0d", e, size, i + 1);
      end
      if (i == 0) begin
        checks++;
        if (lat != 3) begin errors++; $display("FAIL push_latency: got %0d want 3", lat); end
      end
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (ram[i] !== DW'(exp_ram[i-1])) begin
        errors++;
        $display("FAIL push_layout: ram[%0d]=%0d want %0d", i, ram[i], exp_ram[i-1]);
      end
    end
  endtask

  task automatic test_pop_order();
    bit e; logic [DW-1:0] q; int lat; int exp_k;
    while (model_q.size() > 0) begin
      exp_k = model_q.pop_front();
      req(0, 1, '0, e, q, lat);
      checks++;
      if (e !== 1'b0 || q !== DW'(exp_k)) begin
        errors++;
        $display("FAIL pop_order: dout=%0d err=%b want dout=%0d err=0", q, e, exp_k);
      end
      if (model_q.size() == 0) begin
        checks++;
        if (lat != 6 || empty !== 1'b1) begin
          errors++;
          $display("FAIL pop_last: latency=%0d empty=%b want 6 and 1", lat, empty);
        end
      end
    end
  endtask

  task automatic test_pop_empty();
    bit e; logic [DW-1:0] q; int lat; int w0; logic [DW-1:0] d0;
    w0 = wr_cnt; d0 = dout;
    req(0, 1, '0, e, q, lat);
    checks++;
    if (e !== 1'b1 || lat != 1 || wr_cnt != w0 || size !== '0 || dout !== d0) begin
      errors++;
      $display("FAIL pop_empty: err=%b lat=%0d writes=%0d size=%0d dout=%0d want 1,1,0,0,%0d",
               e, lat, wr_cnt - w0, size, dout, d0);
    end
  endtask

  task automatic test_full();
    bit e; logic [DW-1:0] q; int lat; int w0; int k;
    logic [DW-1:0] snap [1:DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      k = int'($urandom_range(0, 255));
      req(1, 0, DW'(k), e, q, lat);
      model_push(k);
    end
    check_heap("fill");
    for (int i = 1; i <= DEPTH; i++) snap[i] = ram[i];
    w0 = wr_cnt;
    req(1, 0, 8'd0, e, q, lat);
    checks++;
    if (e !== 1'b1 || lat != 1 || size !== AW'(DEPTH) || full !== 1'b1 || wr_cnt != w0) begin
      errors++;
      $display("FAIL push_full: err=%b lat=%0d size=%0d full=%b writes=%0d want 1,1,7,1,0",
               e, lat, size, full, wr_cnt - w0);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (ram[i] !== snap[i]) begin
        errors++;
        $display("FAIL full_ram: ram[%0d]=%0d want %0d", i, ram[i], snap[i]);
      end
    end
  endtask

  task automatic test_push_pop_together();
    bit e; logic [DW-1:0] q; int lat; int exp_k;
    do_reset();
    req(1, 0, 8'd40, e, q, lat); model_push(40);
    req(1, 0, 8'd20, e, q, lat); model_push(20);
    exp_k = model_q.pop_front();
    req(1, 1, 8'd99, e, q, lat);
    checks++;
    if (e !== 1'b0 || q !== DW'(exp_k) || size !== AW'(1)) begin
      errors++;
      $display("FAIL push_pop_both: dout=%0d err=%b size=%0d want %0d,0,1", q, e, size, exp_k);
    end
  endtask

  task automatic test_busy_ignored();
    bit e; logic [DW-1:0] q; int lat; int cyc;
    // Heap holds one element here; a push held high during the pop must be dropped.
    pop_req = 1'b1;
    @(posedge clk); @(negedge clk);
    pop_req = 1'b0; push_req = 1'b1; din = 8'd7;
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin
      @(posedge clk); @(negedge clk); cyc++;
    end
    push_req = 1'b0;
    @(posedge clk); @(negedge clk);
    model_q.delete();
    checks++;
    if (size !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored: size=%0d busy=%b want 0,0", size, busy);
    end
    req(0, 1, '0, e, q, lat);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL busy_ignored_empty: err=%b want 1", e); end
  endtask

  task automatic test_reset_mid_sift();
    bit e; logic [DW-1:0] q; int lat;
    do_reset();
    for (int i = 1; i <= 6; i++) req(1, 0, DW'(i * 10), e, q, lat);
    push_req = 1'b1; din = 8'd1;
    @(posedge clk); @(negedge clk);
    push_req = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_sift_busy: busy=%b want 1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || size !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: busy=%b size=%0d empty=%b want 0,0,1", busy, size, empty);
    end
    @(negedge clk); reset = 1'b0;
    model_q.delete();
    req(1, 0, 8'd9, e, q, lat);
    checks++;
    if (ram[1] !== 8'd9 || size !== AW'(1) || e !== 1'b0) begin
      errors++;
      $display("FAIL push_after_reset: ram1=%0d size=%0d err=%b want 9,1,0", ram[1], size, e);
    end
  endtask

  task automatic test_random();
    bit e; logic [DW-1:0] q; int lat; int k; int exp_k; bit exp_e;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        k = int'($urandom_range(0, 255));
        exp_e = (model_q.size() == DEPTH);
        req(1, 0, DW'(k), e, q, lat);
        if (!exp_e) model_push(k);
        checks++;
        if (e !== exp_e) begin
          errors++;
          $display("FAIL rand_push_err: err=%b want %b", e, exp_e);
        end
      end else begin
        exp_e = (model_q.size() == 0);
        exp_k = exp_e ? 0 : model_q.pop_front();
        req(0, 1, '0, e, q, lat);
        checks++;
        if (e !== exp_e || (!exp_e && q !== DW'(exp_k))) begin
          errors++;
          $display("FAIL rand_pop: dout=%0d err=%b want dout=%0d err=%b", q, e, exp_k, exp_e);
        end
      end
      check_heap("rand");
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_pop_order();
    test_pop_empty();
    test_full();
    test_push_pop_together();
    test_busy_ignored();
    test_reset_mid_sift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
